ifm_fetch_ctrl: RTL and testbench
=================================

Name: ifm_fetch_ctrl

Overview:
- Upstream feeder for the 4-deep IFM shift buffer.
- Walks an IFM_H x IFM_W 8-bit input feature map stored row-major in a single-port SRAM with 1-cycle read latency.
- Pushes pixels into the shift buffer via ifm_read/ifm_input, and flags each cycle in which the buffer holds a complete 1x4 horizontal window for the PE stage.
- Handles start/done sequencing and throttles SRAM reads with PE backpressure.

Parameters:
- IFM_W, 8, pixels per row; must be >= KSIZE.
- IFM_H, 8, number of rows.
- KSIZE, 4, window length; fixed to the shift-buffer depth.
- ADDR_W, 8, SRAM address width; 2**ADDR_W must be >= IFM_W*IFM_H.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  one-cycle pulse; begins a frame, honoured only in IDLE
- pe_ready  input  1  PE can accept windows; gates new SRAM reads
- sram_ren  output  1  SRAM read enable
- sram_addr  output  ADDR_W  SRAM read address
- sram_rdata  input  8  signed SRAM read data, valid the cycle after sram_ren
- ifm_read  output  1  shift-buffer push strobe
- ifm_input  output  8  signed pixel pushed into the buffer
- win_valid  output  1  buffer outputs hold a complete window this cycle
- win_row  output  ADDR_W  row index of the current window
- win_col  output  ADDR_W  column of the window's newest pixel (KSIZE-1 .. IFM_W-1)
- busy  output  1  high from FETCH through DONE
- done  output  1  one-cycle end-of-frame pulse

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; all counters 0.
  - Reset mid-frame aborts the frame immediately.
  - No done pulse is produced after a reset.
- States:
  - IDLE: waits for start. start=1 -> FETCH. row/col counters cleared.
  - FETCH: each cycle with pe_ready=1, drives sram_ren=1 and sram_addr=row*IFM_W+col, then advances col; at col=IFM_W-1, col wraps to 0 and row increments. With pe_ready=0, sram_ren=0 and the counters hold. After the read of the last pixel (row IFM_H-1, col IFM_W-1) is issued -> DRAIN.
  - DRAIN: no new reads. Stays until the push pipeline and win_valid pipeline are empty -> DONE.
  - DONE: done=1 for exactly one cycle -> IDLE.
  - busy is high in FETCH, DRAIN and DONE.
- Push path (cycle t+1 after a read at cycle t):
  - ifm_read=1 and ifm_input=sram_rdata, registered directly from the read pipeline.
  - Each push carries a row/col tag pipelined alongside the read.
  - sram_rdata is ignored in cycles without a read in flight.
- Window flag (cycle t+2, after the buffer has updated):
  - win_valid=1 iff the tagged col >= KSIZE-1; win_row/win_col take that tag.
  - Windows never span rows. Pushes with col < KSIZE-1 refill the buffer and give win_valid=0.
  - Windows per row = IFM_W-KSIZE+1. Total per frame = IFM_H*(IFM_W-KSIZE+1).
  - win_row/win_col hold their last value when win_valid=0.
- Backpressure:
  - pe_ready is sampled only to gate new reads.
  - Reads already in flight still push and flag.
  - The PE must absorb up to 2 further win_valid pulses after deasserting pe_ready.
  - Stall length is unbounded; no pixel is skipped or repeated.
- start while busy is ignored.
- start coincident with reset release is ignored; start must be sampled high with rst_n high.
- Address arithmetic is unsigned, with no wrap within a frame. Data passes through unmodified, as signed 8-bit.

Test Plan:
- Basic frame: 8x8, SRAM[a]=a, pe_ready=1, start at cycle 0.
  - First sram_ren (addr 0) at cycle 1.
  - First win_valid at cycle 6, with buffer {buf3..buf0}={0,1,2,3}, win_row=0, win_col=3.
  - Exactly 40 win_valid pulses.
  - done single pulse at cycle 66; busy low from cycle 67.
- Row boundary: same frame.
  - Pushes of addr 8,9,10 give win_valid=0.
  - addr 11 gives a window {8,9,10,11} with win_row=1, win_col=3.
  - No window ever mixes addr 7 and addr 8.
- Backpressure: drop pe_ready for 10 cycles after the 5th read.
  - At most 2 win_valid pulses arrive during the stall.
  - Resumed sram_addr continues at 5.
  - Still 40 windows, in the same order; done is delayed by 10 cycles.
- Signed data: SRAM holds -128, 127, -1, 0 repeating.
  - ifm_input and the buffer outputs reproduce these values bit-exact.
- Start while busy: pulse start at cycle 20 of a frame.
  - Ignored; the frame is unaffected; only one done pulse.
- Reset mid-frame: assert rst_n low at cycle 30.
  - All outputs 0 immediately; no done pulse.
  - A new start after release runs a full clean 40-window frame from addr 0.

Source files
------------

// File: rtl/ifm_fetch_ctrl.sv
// ifm_fetch_ctrl: walks a row-major IFM in a 1-cycle-latency SRAM, pushes pixels into the
// 4-deep shift buffer and flags complete 1xKSIZE windows. Revision 1.0.
`default_nettype none

module ifm_fetch_ctrl #(
  parameter int IFM_W  = 8,
  parameter int IFM_H  = 8,
  parameter int KSIZE  = 4,
  parameter int ADDR_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              pe_ready,
  output logic              sram_ren,
  output logic [ADDR_W-1:0] sram_addr,
  input  logic signed [7:0] sram_rdata,
  output logic              ifm_read,
  output logic signed [7:0] ifm_input,
  output logic              win_valid,
  output logic [ADDR_W-1:0] win_row,
  output logic [ADDR_W-1:0] win_col,
  output logic              busy,
  output logic              done
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] LAST_COL      = ADDR_W'(IFM_W - 1);
  localparam logic [ADDR_W-1:0] LAST_ROW      = ADDR_W'(IFM_H - 1);
  localparam logic [ADDR_W-1:0] FIRST_WIN_COL = ADDR_W'(KSIZE - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] row;
  logic [ADDR_W-1:0] col;
  logic [ADDR_W-1:0] addr;
  logic              rd_vld;
  logic [ADDR_W-1:0] rd_row;
  logic [ADDR_W-1:0] rd_col;
  logic              last_pix;
  logic              win_hit;

  assign sram_ren  = (state == S_FETCH) && pe_ready;
  assign sram_addr = addr;
  assign last_pix  = (row == LAST_ROW) && (col == LAST_COL);
  assign ifm_read  = rd_vld;
  assign ifm_input = rd_vld ? sram_rdata : 8'sd0;
  assign busy      = (state != S_IDLE);
  assign done      = (state == S_DONE);
  assign win_hit   = rd_vld && (rd_col >= FIRST_WIN_COL);

  // Running address tracks row*IFM_W+col without a multiplier.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      row   <= '0;
      col   <= '0;
      addr  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          row  <= '0;
          col  <= '0;
          addr <= '0;
          if (start) state <= S_FETCH;
        end
        S_FETCH: begin
          if (sram_ren) begin
            addr <= addr + 1'b1;
            if (col == LAST_COL) begin
              col <= '0;
              row <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
            if (last_pix) state <= S_DRAIN;
          end
        end
        // The final push happens here; its window flag lands together with done.
        S_DRAIN: state <= S_DONE;
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld    <= 1'b0;
      rd_row    <= '0;
      rd_col    <= '0;
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
    end else begin
      rd_vld    <= sram_ren;
      win_valid <= win_hit;
      if (sram_ren) begin
        rd_row <= row;
        rd_col <= col;
      end
      if (win_hit) begin
        win_row <= rd_row;
        win_col <= rd_col;
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_ifm_fetch_ctrl.sv
// tb_ifm_fetch_ctrl: directed vector bench for ifm_fetch_ctrl with SRAM and shift-buffer models.
`default_nettype none

module tb_ifm_fetch_ctrl;

  localparam int W    = 8;
  localparam int H    = 8;
  localparam int K    = 4;
  localparam int AW   = 8;
  localparam int NCYC = 110;
  localparam int NWIN = H * (W - K + 1);

  logic              clk = 1'b0;
  logic              rst_n;
  logic              start;
  logic              pe_ready;
  logic              sram_ren;
  logic [AW-1:0]     sram_addr;
  logic signed [7:0] sram_rdata;
  logic              ifm_read;
  logic signed [7:0] ifm_input;
  logic              win_valid;
  logic [AW-1:0]     win_row;
  logic [AW-1:0]     win_col;
  logic              busy;
  logic              done;

  ifm_fetch_ctrl #(.IFM_W(W), .IFM_H(H), .KSIZE(K), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .pe_ready(pe_ready),
    .sram_ren(sram_ren), .sram_addr(sram_addr), .sram_rdata(sram_rdata),
    .ifm_read(ifm_read), .ifm_input(ifm_input), .win_valid(win_valid),
    .win_row(win_row), .win_col(win_col), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [7:0]  mem [256];
  logic [31:0] bufm = '0;

  always @(posedge clk) if (sram_ren) sram_rdata <= mem[sram_addr];
  // Shift buffer: bufm[31:24] is the oldest pixel, bufm[7:0] the newest.
  always @(posedge clk) if (ifm_read) bufm <= {bufm[23:0], ifm_input};

  int checks = 0;
  int passes = 0;

  int ren_a [NCYC];
  int addr_a[NCYC];
  int rd_a  [NCYC];
  int in_a  [NCYC];
  int wv_a  [NCYC];
  int wr_a  [NCYC];
  int wc_a  [NCYC];
  int dn_a  [NCYC];
  int bsy_a [NCYC];
  int buf_a [NCYC];

  typedef struct {
    int cyc; int ren; int addr; int wv; int wrow; int wcol; int dn; int bsy;
  } vec_t;
  vec_t tbl[11];

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic run_frame(input int stall_from, input int stall_len, input int extra_start,
                           input int reset_at, input int reset_len);
    for (int c = 0; c < NCYC; c++) begin
      start    = (c == 0) || (c == extra_start);
      pe_ready = !(c >= stall_from && c < stall_from + stall_len);
      if (c == reset_at) rst_n = 1'b0;
      if (c == reset_at + reset_len) rst_n = 1'b1;
      #1;
      ren_a[c] = int'(sram_ren);   addr_a[c] = int'(sram_addr);
      rd_a[c]  = int'(ifm_read);   in_a[c]   = int'(ifm_input);
      wv_a[c]  = int'(win_valid);  wr_a[c]   = int'(win_row);
      wc_a[c]  = int'(win_col);    dn_a[c]   = int'(done);
      bsy_a[c] = int'(busy);       buf_a[c]  = int'(bufm);
      @(posedge clk); #1;
    end
    start    = 1'b0;
    pe_ready = 1'b1;
  endtask

  task automatic check_table(input string tag);
    for (int i = 0; i < 11; i++) begin
      int c;
      c = tbl[i].cyc;
      chk($sformatf("%s c%0d ren", tag, c), ren_a[c], tbl[i].ren);
      if (tbl[i].addr >= 0) chk($sformatf("%s c%0d addr", tag, c), addr_a[c], tbl[i].addr);
      chk($sformatf("%s c%0d win_valid", tag, c), wv_a[c], tbl[i].wv);
      if (tbl[i].wrow >= 0) chk($sformatf("%s c%0d win_row", tag, c), wr_a[c], tbl[i].wrow);
      if (tbl[i].wcol >= 0) chk($sformatf("%s c%0d win_col", tag, c), wc_a[c], tbl[i].wcol);
      chk($sformatf("%s c%0d done", tag, c), dn_a[c], tbl[i].dn);
      chk($sformatf("%s c%0d busy", tag, c), bsy_a[c], tbl[i].bsy);
    end
  endtask

  task automatic check_frame(input string tag, input int done_cyc);
    int k;
    int np;
    int nd;
    int a;
    k = 0; np = 0; nd = 0;
    for (int c = 0; c < NCYC; c++) begin
      if (rd_a[c] != 0) begin
        if (np < W * H) chk($sformatf("%s push%0d data", tag, np), in_a[c], int'($signed(mem[np])));
        np++;
      end
      if (wv_a[c] != 0) begin
        if (k < NWIN) begin
          a = (k / (W - K + 1)) * W + (K - 1) + k % (W - K + 1);
          chk($sformatf("%s win%0d row", tag, k), wr_a[c], a / W);
          chk($sformatf("%s win%0d col", tag, k), wc_a[c], a % W);
          chk($sformatf("%s win%0d buf", tag, k), buf_a[c],
              int'({mem[a-3], mem[a-2], mem[a-1], mem[a]}));
        end
        k++;
      end
      if (dn_a[c] != 0) begin
        nd++;
        chk($sformatf("%s done cycle", tag), c, done_cyc);
      end
    end
    chk($sformatf("%s push count", tag), np, W * H);
    chk($sformatf("%s window count", tag), k, NWIN);
    chk($sformatf("%s done count", tag), nd, 1);
    chk($sformatf("%s busy after done", tag), bsy_a[done_cyc + 1], 0);
  endtask

  task automatic fill_linear();
    for (int i = 0; i < 256; i++) mem[i] = 8'(i);
  endtask

  initial begin
    int nwv;
    int nd;
    tbl[0]  = '{0,  0, 0,  0, -1, -1, 0, 0};
    tbl[1]  = '{1,  1, 0,  0, -1, -1, 0, 1};
    tbl[2]  = '{2,  1, 1,  0, -1, -1, 0, 1};
    tbl[3]  = '{5,  1, 4,  0, -1, -1, 0, 1};
    tbl[4]  = '{6,  1, 5,  1,  0,  3, 0, 1};
    tbl[5]  = '{11, 1, 10, 0,  0,  7, 0, 1};
    tbl[6]  = '{14, 1, 13, 1,  1,  3, 0, 1};
    tbl[7]  = '{64, 1, 63, 1,  7,  5, 0, 1};
    tbl[8]  = '{65, 0, -1, 1,  7,  6, 0, 1};
    tbl[9]  = '{66, 0, -1, 1,  7,  7, 1, 1};
    tbl[10] = '{67, 0, -1, 0,  7,  7, 0, 0};
    fill_linear();

    rst_n = 1'b0; start = 1'b0; pe_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset ren", int'(sram_ren), 0);
    chk("reset addr", int'(sram_addr), 0);
    chk("reset ifm_read", int'(ifm_read), 0);
    chk("reset win_valid", int'(win_valid), 0);
    chk("reset busy", int'(busy), 0);
    chk("reset done", int'(done), 0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Basic frame with linear data
    run_frame(-1, 0, -1, -1, 0);
    check_table("basic");
    check_frame("basic", 66);

    // Backpressure after the 5th read: pe_ready low for cycles 6..15
    run_frame(6, 10, -1, -1, 0);
    nwv = 0;
    for (int c = 6; c < 16; c++) begin
      nwv += wv_a[c];
      chk($sformatf("stall c%0d ren", c), ren_a[c], 0);
    end
    chk("stall windows <= 2", int'(nwv <= 2), 1);
    chk("resume ren", ren_a[16], 1);
    chk("resume addr", addr_a[16], 5);
    check_frame("stall", 76);

    // Start pulse while busy must be ignored
    run_frame(-1, 0, 20, -1, 0);
    check_table("busy_start");
    check_frame("busy_start", 66);

    // Signed data pattern
    for (int i = 0; i < 256; i++) begin
      case (i % 4)
        0: mem[i] = 8'h80;
        1: mem[i] = 8'h7f;
        2: mem[i] = 8'hff;
        default: mem[i] = 8'h00;
      endcase
    end
    run_frame(-1, 0, -1, -1, 0);
    check_frame("signed", 66);
    fill_linear();

    // Reset at cycle 30, released at 32; no done, everything cleared at once
    run_frame(-1, 0, -1, 30, 2);
    chk("midrst ren", ren_a[30], 0);
    chk("midrst addr", addr_a[30], 0);
    chk("midrst ifm_read", rd_a[30], 0);
    chk("midrst ifm_input", in_a[30], 0);
    chk("midrst win_valid", wv_a[30], 0);
    chk("midrst win_row", wr_a[30], 0);
    chk("midrst win_col", wc_a[30], 0);
    chk("midrst busy", bsy_a[30], 0);
    nd = 0;
    for (int c = 0; c < NCYC; c++) nd += dn_a[c];
    chk("midrst done count", nd, 0);
    chk("midrst idle at end", bsy_a[NCYC - 1], 0);

    run_frame(-1, 0, -1, -1, 0);
    check_table("post_rst");
    check_frame("post_rst", 66);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

`default_nettype wire
